// File: rtl/huffman_pkg.sv
// Shared definitions for the canonical Huffman encoder pipeline.
//   state_t           : control states of the frequency/sort stage
//   *_DEF localparams : default alphabet size and datapath widths
package huffman_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SORT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SYMBOLS_DEF      = 16;
  localparam int FREQ_WIDTH_DEF   = 32;
  localparam int SYMBOL_WIDTH_DEF = 5;

endpackage

// File: rtl/oets_cmp_swap.sv
// Compare-exchange cell for odd-even transposition sort.
// Purely combinational. When enabled and the low lane holds a strictly larger
// frequency than the high lane, the (freq, sym) pairs are exchanged; otherwise
// both pairs pass straight through. The strict compare keeps equal
// frequencies in their incoming order, so the overall sort is stable.
//   en          : this pair is active in the current phase
//   lo_*/hi_*   : incoming pair for the lower / higher lane
//   lo_*_o/hi_* : outgoing pair for the lower / higher lane
module oets_cmp_swap #(
  parameter int FREQ_WIDTH   = 32,
  parameter int SYMBOL_WIDTH = 5
) (
  input  logic                    en,
  input  logic [FREQ_WIDTH-1:0]   lo_freq,
  input  logic [SYMBOL_WIDTH-1:0] lo_sym,
  input  logic [FREQ_WIDTH-1:0]   hi_freq,
  input  logic [SYMBOL_WIDTH-1:0] hi_sym,
  output logic [FREQ_WIDTH-1:0]   lo_freq_o,
  output logic [SYMBOL_WIDTH-1:0] lo_sym_o,
  output logic [FREQ_WIDTH-1:0]   hi_freq_o,
  output logic [SYMBOL_WIDTH-1:0] hi_sym_o
);

  logic swap;

  assign swap      = en && (lo_freq > hi_freq);
  assign lo_freq_o = swap ? hi_freq : lo_freq;
  assign lo_sym_o  = swap ? hi_sym  : lo_sym;
  assign hi_freq_o = swap ? lo_freq : hi_freq;
  assign hi_sym_o  = swap ? lo_sym  : hi_sym;

endmodule

// File: rtl/stream_sorter_oets.sv
// Frequency-generation stage of the canonical Huffman encoder.
// Builds a per-symbol histogram from a symbol stream, then sorts the
// (symbol, frequency) lanes into ascending frequency order with one
// odd-even transposition phase per clock.
//   clk, reset              : clock; asynchronous active-high reset
//   symbol_in, valid_in     : incoming symbol stream
//   ready_in                : low only while sorting (symbols then dropped)
//   sorted_frequencies_flat : lane i at [i*FREQ_WIDTH +: FREQ_WIDTH]
//   sorted_symbol_flat      : lane i at [i*SYMBOL_WIDTH +: SYMBOL_WIDTH]
//   sorted_done             : lanes hold a finished sort (level)
module stream_sorter_oets
  import huffman_pkg::*;
#(
  parameter int SYMBOLS      = SYMBOLS_DEF,
  parameter int FREQ_WIDTH   = FREQ_WIDTH_DEF,
  parameter int SYMBOL_WIDTH = SYMBOL_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [SYMBOL_WIDTH-1:0]         symbol_in,
  input  logic                            valid_in,
  output logic                            ready_in,
  output logic [SYMBOLS*FREQ_WIDTH-1:0]   sorted_frequencies_flat,
  output logic [SYMBOLS*SYMBOL_WIDTH-1:0] sorted_symbol_flat,
  output logic                            sorted_done
);

  localparam int                PASS_W    = $clog2(SYMBOLS) + 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(SYMBOLS - 1);

  state_t                  state_q, state_d;
  logic [PASS_W-1:0]       pass_q, pass_d;
  logic [FREQ_WIDTH-1:0]   freq_q [SYMBOLS];
  logic [FREQ_WIDTH-1:0]   freq_d [SYMBOLS];
  logic [SYMBOL_WIDTH-1:0] sym_q  [SYMBOLS];
  logic [SYMBOL_WIDTH-1:0] sym_d  [SYMBOLS];

  // Lane values after the current sort phase.
  logic [FREQ_WIDTH-1:0]   net_freq [SYMBOLS];
  logic [SYMBOL_WIDTH-1:0] net_sym  [SYMBOLS];

  // Compare-exchange outputs; cell i handles lanes (i, i+1).
  logic [FREQ_WIDTH-1:0]   cs_lo_freq [SYMBOLS-1];
  logic [SYMBOL_WIDTH-1:0] cs_lo_sym  [SYMBOLS-1];
  logic [FREQ_WIDTH-1:0]   cs_hi_freq [SYMBOLS-1];
  logic [SYMBOL_WIDTH-1:0] cs_hi_sym  [SYMBOLS-1];

  logic [SYMBOLS-1:0]      hit;       // symbol_in selects lane i
  logic [FREQ_WIDTH-1:0]   freq_inc [SYMBOLS];
  logic                    accept;

  assign ready_in    = (state_q != SORT);
  assign sorted_done = (state_q == DONE);
  assign accept      = valid_in && ready_in;

  // Counting only happens while lanes are in identity order, so lane i is
  // symbol i. Out-of-range symbols match no lane and are silently absorbed.
  for (genvar i = 0; i < SYMBOLS; i++) begin : g_lane
    assign hit[i]      = (symbol_in == SYMBOL_WIDTH'(i));
    assign freq_inc[i] = (freq_q[i] == '1) ? freq_q[i] : freq_q[i] + 1'b1;
    assign sorted_frequencies_flat[i*FREQ_WIDTH +: FREQ_WIDTH]     = freq_q[i];
    assign sorted_symbol_flat[i*SYMBOL_WIDTH +: SYMBOL_WIDTH]      = sym_q[i];
  end

  for (genvar i = 0; i < SYMBOLS - 1; i++) begin : g_cs
    oets_cmp_swap #(
      .FREQ_WIDTH  (FREQ_WIDTH),
      .SYMBOL_WIDTH(SYMBOL_WIDTH)
    ) u_cs (
      .en       (pass_q[0] == 1'(i % 2)),
      .lo_freq  (freq_q[i]),
      .lo_sym   (sym_q[i]),
      .hi_freq  (freq_q[i+1]),
      .hi_sym   (sym_q[i+1]),
      .lo_freq_o(cs_lo_freq[i]),
      .lo_sym_o (cs_lo_sym[i]),
      .hi_freq_o(cs_hi_freq[i]),
      .hi_sym_o (cs_hi_sym[i])
    );
  end

  // Each lane takes the low output of the cell it starts, or the high output
  // of the cell it ends, depending on which of the two is active this phase.
  // Edge lanes with no active partner simply hold.
  for (genvar j = 0; j < SYMBOLS; j++) begin : g_route
    if (j == 0) begin : g_first
      assign net_freq[j] = pass_q[0] ? freq_q[j] : cs_lo_freq[j];
      assign net_sym[j]  = pass_q[0] ? sym_q[j]  : cs_lo_sym[j];
    end else if (j == SYMBOLS - 1) begin : g_last
      assign net_freq[j] = pass_q[0] ? freq_q[j] : cs_hi_freq[j-1];
      assign net_sym[j]  = pass_q[0] ? sym_q[j]  : cs_hi_sym[j-1];
    end else begin : g_mid
      assign net_freq[j] = (pass_q[0] == 1'(j % 2)) ? cs_lo_freq[j] : cs_hi_freq[j-1];
      assign net_sym[j]  = (pass_q[0] == 1'(j % 2)) ? cs_lo_sym[j]  : cs_hi_sym[j-1];
    end
  end

  // NOTE: every signal driven here gets a hold default first so no path
  // leaves it unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    freq_d  = freq_q;
    sym_d   = sym_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < SYMBOLS; i++)
            if (hit[i]) freq_d[i] = freq_inc[i];
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (accept) begin
          for (int i = 0; i < SYMBOLS; i++)
            if (hit[i]) freq_d[i] = freq_inc[i];
        end else begin
          pass_d  = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        freq_d = net_freq;
        sym_d  = net_sym;
        pass_d = pass_q + 1'b1;
        if (pass_q == LAST_PASS) state_d = DONE;
      end
      DONE: begin
        // A new stream restarts from a clean identity histogram.
        if (accept) begin
          for (int i = 0; i < SYMBOLS; i++) begin
            freq_d[i] = hit[i] ? FREQ_WIDTH'(1) : '0;
            sym_d[i]  = SYMBOL_WIDTH'(i);
          end
          state_d = COUNT;
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the lane array is flip-flops, not RAM, and its reset contents
  // (identity symbols, zero counts) are observable, so it is reset too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pass_q  <= '0;
      for (int i = 0; i < SYMBOLS; i++) begin
        freq_q[i] <= '0;
        sym_q[i]  <= SYMBOL_WIDTH'(i);
      end
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      freq_q  <= freq_d;
      sym_q   <= sym_d;
    end
  end

endmodule

// File: tb/tb_stream_sorter_oets.sv
// Scoreboard bench for stream_sorter_oets: each stream pushes its expected
// sorted lanes; a monitor pops and compares whenever sorted_done rises.
module tb_stream_sorter_oets;

  localparam int S  = 16;
  localparam int FW = 32;
  localparam int SW = 5;

  typedef struct {
    logic [S*FW-1:0] freq;
    logic [S*SW-1:0] sym;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [SW-1:0]   symbol_in;
  logic            valid_in;
  logic            ready_in;
  logic [S*FW-1:0] sorted_frequencies_flat;
  logic [S*SW-1:0] sorted_symbol_flat;
  logic            sorted_done;

  int   checks;
  int   failures;
  exp_t sb[$];

  stream_sorter_oets #(
    .SYMBOLS     (S),
    .FREQ_WIDTH  (FW),
    .SYMBOL_WIDTH(SW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .symbol_in              (symbol_in),
    .valid_in               (valid_in),
    .ready_in               (ready_in),
    .sorted_frequencies_flat(sorted_frequencies_flat),
    .sorted_symbol_flat     (sorted_symbol_flat),
    .sorted_done            (sorted_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [S*FW-1:0] act,
                       input logic [S*FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int syms[S], input int fr[S]);
    exp_t e;
    for (int i = 0; i < S; i++) begin
      e.sym[i*SW +: SW]  = SW'(syms[i]);
      e.freq[i*FW +: FW] = FW'(fr[i]);
    end
    return e;
  endfunction

  function automatic logic [S*SW-1:0] identity_syms();
    logic [S*SW-1:0] v;
    for (int i = 0; i < S; i++) v[i*SW +: SW] = SW'(i);
    return v;
  endfunction

  // Drives one symbol per cycle, then one valid_in=0 cycle. The check at the
  // second symbol confirms the first accept left sorted_done low.
  task automatic send_stream(input int q[$]);
    foreach (q[k]) begin
      @(negedge clk);
      if (k == 1) check("done_clear_on_accept", {511'd0, sorted_done}, '0);
      symbol_in = SW'(q[k]);
      valid_in  = 1'b1;
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Counts rising edges until sorted_done, from the valid_in=0 cycle.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 64) begin
      @(posedge clk);
      #1;
      n++;
      if (sorted_done) break;
    end
    if (!sorted_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got sorted_done=0 after %0d clocks, required 1", n);
    end
  endtask

  // Monitor: compares lanes against the scoreboard on each sorted_done rise.
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_prev = 1'b0;
      end else begin
        if (sorted_done && !done_prev) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got sorted_done=1 with no result expected");
          end else begin
            e = sb.pop_front();
            check("sorted_freq", sorted_frequencies_flat, e.freq);
            check("sorted_sym", {{(S*FW-S*SW){1'b0}}, sorted_symbol_flat},
                  {{(S*FW-S*SW){1'b0}}, e.sym});
          end
        end
        done_prev = sorted_done;
      end
    end
  end

  initial begin : stimulus
    int q[$];
    int syms[S];
    int fr[S];
    int n;

    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    valid_in  = 1'b0;
    symbol_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check("reset_done", {511'd0, sorted_done}, '0);
    check("reset_ready", {511'd0, ready_in}, {511'd0, 1'b1});
    check("reset_freq", sorted_frequencies_flat, '0);
    check("reset_sym", {{(S*FW-S*SW){1'b0}}, sorted_symbol_flat},
          {{(S*FW-S*SW){1'b0}}, identity_syms()});

    // Idle with no valid: nothing must happen.
    repeat (25) @(negedge clk);
    check("idle_no_sort", {511'd0, sorted_done}, '0);

    // Stream A from IDLE.
    syms = '{10, 11, 12, 13, 14, 4, 5, 6, 7, 8, 9, 15, 1, 2, 3, 0};
    fr   = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3};
    sb.push_back(mk_exp(syms, fr));
    q = '{0, 15, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 8, 9, 0, 0};
    send_stream(q);
    wait_done(n);
    check("latency_a", FW'(n), FW'(S + 1));

    // Stream B restarting from DONE; latency measured again.
    syms = '{12, 13, 14, 15, 4, 5, 6, 7, 8, 9, 10, 11, 0, 1, 2, 3};
    fr   = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2};
    sb.push_back(mk_exp(syms, fr));
    q = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    send_stream(q);
    wait_done(n);
    check("latency_b", FW'(n), FW'(S + 1));

    // Stream C: 5,5,5 with symbols offered while sorting (must be dropped).
    syms = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 5};
    fr   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    sb.push_back(mk_exp(syms, fr));
    q = '{5, 5, 5};
    send_stream(q);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      symbol_in = SW'(7);
      valid_in  = 1'b1;
      if (k == 0 || k == 9)
        check("ready_low_in_sort", {511'd0, ready_in}, '0);
    end
    @(negedge clk);
    valid_in = 1'b0;
    wait_done(n);

    // Stream D: out-of-range symbols are accepted but never counted.
    syms = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 3};
    fr   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
    sb.push_back(mk_exp(syms, fr));
    q = '{3, 20, 31, 3};
    send_stream(q);
    wait_done(n);

    // Reset in the middle of a sort: outputs return to reset values at once.
    q = '{1, 2, 2};
    send_stream(q);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midsort_reset_done", {511'd0, sorted_done}, '0);
    check("midsort_reset_ready", {511'd0, ready_in}, {511'd0, 1'b1});
    check("midsort_reset_freq", sorted_frequencies_flat, '0);
    check("midsort_reset_sym", {{(S*FW-S*SW){1'b0}}, sorted_symbol_flat},
          {{(S*FW-S*SW){1'b0}}, identity_syms()});
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_reset_idle", {511'd0, sorted_done}, '0);
    check("scoreboard_drained", FW'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
